// File: rtl/modmul_radix.sv
// Radix-2^R interleaved modular multiplier: p = (a*b) mod n, R bits of b per cycle, MSB digit first.
// Operands are latched on an accepted start; n==0 or a>=n completes at once with err.
module modmul_radix #(
    parameter int W  = 2048,
    parameter int R  = 4,
    parameter int CW = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         ready,
    output logic         done,
    output logic         err,
    output logic [W-1:0] p
);
    localparam int DW = W + R + 2;
    localparam int ND = W / R;

    if (!(R == 1 || R == 2 || R == 4 || R == 8) || (W % R) != 0 || (ND >> CW) != 0) begin : g_bad_param
        $error("modmul_radix: illegal parameters W=%0d R=%0d CW=%0d", W, R, CW);
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q;
    logic [W-1:0]  a_q, b_q, n_q, acc_q, p_q;
    logic [CW-1:0] cnt_q;
    logic          done_q, err_q;
    logic          ops_ok, accept, last;
    logic [R-1:0]  digit;
    logic [DW-1:0] t_d;
    logic [W-1:0]  acc_d;

    assign ready  = (state_q == IDLE);
    assign ops_ok = (n != '0) && (a < n);
    assign accept = ready && start && ops_ok;
    assign last   = (cnt_q == CW'(ND - 1));
    assign digit  = b_q[W-1 -: R];

    // NOTE: blocking '=' chains the adder and the R+1 compare-subtract stages within one cycle;
    // t_d is fully assigned before any conditional update, so no latch can form.
    always_comb begin
        t_d = {{(R + 2){1'b0}}, acc_q} << R;
        for (int k = 0; k < R; k++) begin
            if (digit[k]) t_d = t_d + ({{(R + 2){1'b0}}, a_q} << k);
        end
        for (int j = R; j >= 0; j--) begin
            if (t_d >= ({{(R + 2){1'b0}}, n_q} << j)) t_d = t_d - ({{(R + 2){1'b0}}, n_q} << j);
        end
        acc_d = t_d[W-1:0];
    end

    // NOTE: operand registers carry no reset; BUSY is only ever entered by loading them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
            n_q <= n;
        end else if (state_q == BUSY) begin
            b_q <= b_q << R;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            p_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !ops_ok) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        p_q    <= '0;
                    end else if (start) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (abort) begin
                        state_q <= IDLE;
                        p_q     <= '0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else if (last) begin
                        state_q <= IDLE;
                        p_q     <= acc_d;
                        done_q  <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done = done_q;
    assign err  = err_q;
    assign p    = p_q;
endmodule
